flags_unit: RTL and testbench

- Sequential consumer of the ALU's result/flags interface.
- Accepts each ALU result via valid/ready and maintains the architectural flags register: compare bits from CMP, sticky overflow and div-by-zero.
- Resolves branch conditions against the flags and stages non-CMP results for register-file writeback.
- Raises a trap and stalls when an enabled error flag fires.

---
 rtl/flags_unit_pkg.sv | 55 +++++
 rtl/flags_cond_eval.sv | 36 +++
 rtl/flags_unit.sv | 150 +++++++++++++++
 tb/tb_flags_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flags_unit_pkg.sv
// Shared constants for the ALU flags consumer: widths, opcodes, rflags bit map,
// branch condition codes, FSM states and the trap-mask helper.
package flags_unit_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int OPCODE_WIDTH = 4;
    localparam int RFLAGS_WIDTH = 5;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL = 4'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_DIV = 4'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND = 4'h4;
    localparam logic [OPCODE_WIDTH-1:0] OP_OR  = 4'h5;
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR = 4'h6;
    localparam logic [OPCODE_WIDTH-1:0] OP_CMP = 4'h7;
    localparam logic [OPCODE_WIDTH-1:0] OP_SHL = 4'h8;
    localparam logic [OPCODE_WIDTH-1:0] OP_SHR = 4'h9;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOV = 4'hA;

    localparam int RF_DIV0 = 0;
    localparam int RF_LT   = 1;
    localparam int RF_EQ   = 2;
    localparam int RF_GT   = 3;
    localparam int RF_OV   = 4;

    localparam int TRAP_DIV0 = 0;
    localparam int TRAP_OV   = 1;

    typedef enum logic [2:0] {
        BR_ALWAYS = 3'd0,
        BR_EQ     = 3'd1,
        BR_NE     = 3'd2,
        BR_LT     = 3'd3,
        BR_GT     = 3'd4,
        BR_LE     = 3'd5,
        BR_GE     = 3'd6,
        BR_OV     = 3'd7
    } br_cond_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    // Error flags that are both raised by the ALU and enabled in the mask.
    function automatic logic [1:0] trap_causes(input logic [RFLAGS_WIDTH-1:0] flags,
                                               input logic [1:0]              en);
        logic [1:0] c;
        c[TRAP_DIV0] = flags[RF_DIV0] & en[TRAP_DIV0];
        c[TRAP_OV]   = flags[RF_OV]   & en[TRAP_OV];
        return c;
    endfunction

endpackage

// File: rtl/flags_cond_eval.sv
// Combinational branch-condition evaluator over an rflags snapshot.
// Zero latency; no flow control.
module flags_cond_eval
    import flags_unit_pkg::*;
(
    input  logic [RFLAGS_WIDTH-1:0] flags_i,
    input  logic [2:0]              cond_i,
    output logic                    taken_o
);

    logic lt;
    logic eq;
    logic gt;
    logic ov;

    assign lt = flags_i[RF_LT];
    assign eq = flags_i[RF_EQ];
    assign gt = flags_i[RF_GT];
    assign ov = flags_i[RF_OV];

    always_comb begin
        taken_o = 1'b0;
        case (br_cond_e'(cond_i))
            BR_ALWAYS: taken_o = 1'b1;
            BR_EQ:     taken_o = eq;
            BR_NE:     taken_o = ~eq;
            BR_LT:     taken_o = lt;
            BR_GT:     taken_o = gt;
            BR_LE:     taken_o = lt | eq;
            BR_GE:     taken_o = gt | eq;
            BR_OV:     taken_o = ov;
            default:   taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flags_unit.sv
// ALU result consumer: architectural rflags, branch resolve (1 cycle), writeback stage, trap FSM.
// Backpressure via in_ready (blocked in TRAP or by an undrained result); FLAGS_UNIT_FWD_EN forwards CMP flags to a same-cycle branch.
module flags_unit #(
    parameter int DATA_WIDTH   = flags_unit_pkg::DATA_WIDTH,
    parameter int OPCODE_WIDTH = flags_unit_pkg::OPCODE_WIDTH,
    parameter int RFLAGS_WIDTH = flags_unit_pkg::RFLAGS_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH-1:0] in_opcode,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [RFLAGS_WIDTH-1:0] in_rflags,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    input  logic                    br_req,
    input  logic [2:0]              br_cond,
    output logic                    br_valid,
    output logic                    br_taken,
    input  logic [1:0]              trap_en,
    output logic                    trap,
    output logic [1:0]              trap_cause,
    input  logic                    trap_ack,
    input  logic                    clr_sticky,
    output logic [RFLAGS_WIDTH-1:0] rflags
);

    import flags_unit_pkg::*;

    state_e                  state_q;
    logic                    trap_q;
    logic [1:0]              trap_cause_q;
    logic [RFLAGS_WIDTH-1:0] rflags_q;
    logic [RFLAGS_WIDTH-1:0] rflags_d;
    logic                    res_valid_q;
    logic                    res_valid_d;
    logic [DATA_WIDTH-1:0]   res_data_q;
    logic [DATA_WIDTH-1:0]   res_data_d;
    logic                    br_valid_q;
    logic                    br_taken_q;
    logic                    br_taken_d;

    logic                    accept;
    logic                    is_cmp;
    logic [1:0]              trap_mask;
    logic                    trap_hit;
    logic [RFLAGS_WIDTH-1:0] eval_flags;

    // Gated by rst so every output reads 0 while reset is held.
    assign in_ready  = ~rst & (state_q == ST_IDLE) & (~res_valid_q | res_ready);
    assign accept    = in_valid & in_ready;
    assign is_cmp    = (in_opcode == OP_CMP);
    assign trap_mask = trap_causes(in_rflags, trap_en);
    assign trap_hit  = accept & (|trap_mask);

    always_comb begin
        rflags_d = rflags_q;
        if (accept && is_cmp) begin
            rflags_d[RF_GT:RF_LT] = in_rflags[RF_GT:RF_LT];
        end
        // A same-cycle set beats clr_sticky, so an error is never silently dropped.
        rflags_d[RF_DIV0] = (rflags_q[RF_DIV0] & ~clr_sticky) | (accept & in_rflags[RF_DIV0]);
        rflags_d[RF_OV]   = (rflags_q[RF_OV]   & ~clr_sticky) | (accept & in_rflags[RF_OV]);
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        if (accept && !is_cmp && !trap_hit) begin
            res_valid_d = 1'b1;
            res_data_d  = in_data;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

`ifdef FLAGS_UNIT_FWD_EN
    always_comb begin
        eval_flags = rflags_q;
        if (accept && is_cmp) begin
            eval_flags[RF_GT:RF_LT] = in_rflags[RF_GT:RF_LT];
        end
    end
`else
    assign eval_flags = rflags_q;
`endif

    flags_cond_eval u_cond_eval (
        .flags_i (eval_flags),
        .cond_i  (br_cond),
        .taken_o (br_taken_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            trap_q       <= 1'b0;
            trap_cause_q <= 2'b00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trap_hit) begin
                        state_q      <= ST_TRAP;
                        trap_q       <= 1'b1;
                        trap_cause_q <= trap_mask;
                    end
                end
                ST_TRAP: begin
                    if (trap_ack) begin
                        state_q      <= ST_IDLE;
                        trap_q       <= 1'b0;
                        trap_cause_q <= 2'b00;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    trap_q       <= 1'b0;
                    trap_cause_q <= 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rflags_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            br_valid_q  <= 1'b0;
            br_taken_q  <= 1'b0;
        end else begin
            rflags_q    <= rflags_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            br_valid_q  <= br_req;
            br_taken_q  <= br_req & br_taken_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign br_valid   = br_valid_q;
    assign br_taken   = br_taken_q;
    assign trap       = trap_q;
    assign trap_cause = trap_cause_q;
    assign rflags     = rflags_q;

endmodule

// File: tb/tb_flags_unit.sv
// Directed and randomized checks of flags_unit against a transaction-level model.
module tb_flags_unit;
    import flags_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [15:0] in_data;
    logic [4:0]  in_rflags;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        br_req;
    logic [2:0]  br_cond;
    logic        br_valid;
    logic        br_taken;
    logic [1:0]  trap_en;
    logic        trap;
    logic [1:0]  trap_cause;
    logic        trap_ack;
    logic        clr_sticky;
    logic [4:0]  rflags;

    always #5 clk = ~clk;

    flags_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_data    (in_data),
        .in_rflags  (in_rflags),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .br_req     (br_req),
        .br_cond    (br_cond),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .trap_en    (trap_en),
        .trap       (trap),
        .trap_cause (trap_cause),
        .trap_ack   (trap_ack),
        .clr_sticky (clr_sticky),
        .rflags     (rflags)
    );

    int checks   = 0;
    int failures = 0;

    bit          m_lt, m_eq, m_gt, m_div0, m_ov, m_trap;
    bit [1:0]    m_cause;
    int unsigned wb_q[$];
    bit          exp_br_valid, exp_br_taken;
    bit          fwd_expect;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_true(input bit [2:0] c, input bit lt, input bit eq,
                                     input bit gt, input bit ov);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return eq;
            3'd2:    return !eq;
            3'd3:    return lt;
            3'd4:    return gt;
            3'd5:    return lt || eq;
            3'd6:    return gt || eq;
            default: return ov;
        endcase
    endfunction

    task automatic model_reset();
        m_lt = 0; m_eq = 0; m_gt = 0; m_div0 = 0; m_ov = 0;
        m_trap = 0; m_cause = 2'b00;
        wb_q.delete();
        exp_br_valid = 0; exp_br_taken = 0;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_opcode = OP_ADD; in_data = 16'h0; in_rflags = 5'b0;
        res_ready = 1; br_req = 0; br_cond = 3'd0; trap_en = 2'b00;
        trap_ack = 0; clr_sticky = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"},   in_ready,   0);
        chk({tag, "_res_valid"},  res_valid,  0);
        chk({tag, "_res_data"},   res_data,   0);
        chk({tag, "_br_valid"},   br_valid,   0);
        chk({tag, "_br_taken"},   br_taken,   0);
        chk({tag, "_trap"},       trap,       0);
        chk({tag, "_trap_cause"}, trap_cause, 0);
        chk({tag, "_rflags"},     rflags,     0);
    endtask

    // Called just after a rising edge with inputs already driven; ends just after the next edge.
    task automatic cycle();
        bit       acc, hit, exp_rdy, fl, fe, fg;
        bit [1:0] mask;
        #1;
        exp_rdy = !m_trap && (wb_q.size() == 0 || res_ready);
        chk("in_ready", in_ready, exp_rdy);
        chk("res_valid_pre", res_valid, wb_q.size() != 0);
        if (wb_q.size() != 0) chk("res_data_pre", res_data, wb_q[0]);

        acc = in_valid && exp_rdy;
        if (wb_q.size() != 0 && res_ready) void'(wb_q.pop_front());

        fl = m_lt; fe = m_eq; fg = m_gt;
`ifdef FLAGS_UNIT_FWD_EN
        if (acc && in_opcode == OP_CMP) begin
            fl = in_rflags[1]; fe = in_rflags[2]; fg = in_rflags[3];
        end
`endif
        exp_br_valid = br_req;
        exp_br_taken = br_req && cond_true(br_cond, fl, fe, fg, m_ov);

        mask = {in_rflags[4] & trap_en[1], in_rflags[0] & trap_en[0]};
        hit  = acc && (mask != 2'b00);
        if (clr_sticky) begin m_div0 = 0; m_ov = 0; end
        if (acc && in_rflags[0]) m_div0 = 1;
        if (acc && in_rflags[4]) m_ov = 1;
        if (acc && in_opcode == OP_CMP) begin
            m_lt = in_rflags[1]; m_eq = in_rflags[2]; m_gt = in_rflags[3];
        end
        if (acc && in_opcode != OP_CMP && !hit) wb_q.push_back(32'(in_data));
        if (hit) begin
            m_trap = 1; m_cause = mask;
        end else if (m_trap && trap_ack) begin
            m_trap = 0; m_cause = 2'b00;
        end

        @(posedge clk);
        #1;
        chk("rflags", rflags, {m_ov, m_gt, m_eq, m_lt, m_div0});
        chk("trap", trap, m_trap);
        chk("trap_cause", trap_cause, m_cause);
        chk("br_valid", br_valid, exp_br_valid);
        if (exp_br_valid) chk("br_taken", br_taken, exp_br_taken);
        chk("res_valid", res_valid, wb_q.size() != 0);
        if (wb_q.size() != 0) chk("res_data", res_data, wb_q[0]);
    endtask

    task automatic pulse_reset();
        rst = 1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        idle_inputs();
    endtask

    initial begin
`ifdef FLAGS_UNIT_FWD_EN
        fwd_expect = 1;
`else
        fwd_expect = 0;
`endif
        rst = 1;
        idle_inputs();
        model_reset();
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 0;

        // CMP sets EQ, then branch on EQ / NE
        in_valid = 1; in_opcode = OP_CMP; in_rflags = 5'b00100; in_data = 16'h5555;
        cycle();
        chk("cmp_rflags", rflags, 5'b00100);
        chk("cmp_no_wb", res_valid, 0);
        idle_inputs(); br_req = 1; br_cond = BR_EQ;
        cycle();
        chk("eq_valid", br_valid, 1);
        chk("eq_taken", br_taken, 1);
        br_cond = BR_NE;
        cycle();
        chk("ne_taken", br_taken, 0);
        idle_inputs();
        cycle();
        chk("br_valid_low", br_valid, 0);

        // Overflow is sticky until clr_sticky
        res_ready = 0; in_valid = 1; in_opcode = OP_ADD; in_data = 16'h7FFF; in_rflags = 5'b10000;
        cycle();
        chk("add_res_valid", res_valid, 1);
        chk("add_res_data", res_data, 16'h7FFF);
        res_ready = 1; in_data = 16'h0001; in_rflags = 5'b00000;
        cycle();
        chk("ov_sticky", rflags[4], 1);
        idle_inputs(); clr_sticky = 1;
        cycle();
        chk("ov_cleared", rflags[4], 0);

        // Div-by-zero trap
        idle_inputs(); in_valid = 1; in_opcode = OP_DIV; in_data = 16'h1234;
        in_rflags = 5'b00001; trap_en = 2'b01;
        cycle();
        chk("trap_set", trap, 1);
        chk("trap_cause_div0", trap_cause, 2'b01);
        chk("trap_no_wb", res_valid, 0);
        chk("trap_in_ready", in_ready, 0);
        idle_inputs(); in_valid = 1; in_data = 16'hBEEF;
        cycle();
        idle_inputs(); trap_ack = 1;
        cycle();
        chk("trap_cleared", trap, 0);
        idle_inputs();
        #1;
        chk("ready_after_ack", in_ready, 1);

        // Back-to-back with a 3-cycle writeback stall
        res_ready = 0; in_valid = 1; in_opcode = OP_SUB; in_data = 16'h00A1;
        cycle();
        in_data = 16'h00A2;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_hold", res_data, 16'h00A1);
            chk("stall_ready", in_ready, 0);
        end
        res_ready = 1;
        cycle();
        chk("drain_next", res_data, 16'h00A2);
        in_data = 16'h00A3;
        cycle();
        chk("drain_next2", res_data, 16'h00A3);
        idle_inputs();
        cycle();
        chk("drained", res_valid, 0);

        // CMP and LT branch in the same cycle
        pulse_reset();
        in_valid = 1; in_opcode = OP_CMP; in_rflags = 5'b00010; br_req = 1; br_cond = BR_LT;
        cycle();
        chk("fwd_lt", br_taken, fwd_expect);

        // Reset during TRAP
        idle_inputs(); in_valid = 1; in_opcode = OP_MUL; in_rflags = 5'b10000; trap_en = 2'b10;
        cycle();
        chk("ov_trap_cause", trap_cause, 2'b10);
        idle_inputs(); br_req = 1;
        rst = 1;
        #1;
        check_all_zero("rst_trap");
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        idle_inputs();
        #1;
        chk("ready_after_rst", in_ready, 1);

        // Reset with a pending writeback
        res_ready = 0; in_valid = 1; in_opcode = OP_XOR; in_data = 16'hC0DE;
        cycle();
        chk("pending_wb", res_valid, 1);
        rst = 1;
        #1;
        check_all_zero("rst_wb");
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        idle_inputs();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            in_valid   = ($urandom % 4) != 0;
            in_opcode  = 4'($urandom_range(0, 15));
            in_data    = 16'($urandom);
            in_rflags  = {($urandom % 8) == 0, 3'($urandom), ($urandom % 8) == 0};
            res_ready  = ($urandom % 3) != 0;
            br_req     = ($urandom % 2) != 0;
            br_cond    = 3'($urandom);
            trap_en    = 2'($urandom);
            trap_ack   = m_trap ? (($urandom % 3) == 0) : (($urandom % 2) == 0);
            clr_sticky = ($urandom % 10) == 0;
            cycle();
        end

        idle_inputs(); trap_ack = 1;
        cycle();
        cycle();
        chk("final_res_valid", res_valid, 0);
        chk("final_trap", trap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
